// File: rtl/noise_est_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noise_est_pkg
// Description : Shared Q2.13 constants and FSM state encoding for the
//               channel noise estimator.
// Revision    : 1.0 - initial release
// ============================================================================
package noise_est_pkg;

    localparam logic signed [15:0] Q13_ONE  = 16'sh2000;
    localparam int                 Q13_FRAC = 13;
    localparam logic [15:0]        PWR_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/noise_est_datapath.sv
`default_nettype none
// ============================================================================
// Module      : noise_est_datapath
// Description : BPSK hard decision, err/sq pipeline and window accumulators.
//               The bias accumulator exists only with NOISE_EST_BIAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module noise_est_datapath
    import noise_est_pkg::*;
#(
    parameter int LOG2_WIN = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               acc_en,
    input  logic signed [15:0] in_sample,
    output logic [16:0]        pwr_q
`ifdef NOISE_EST_BIAS_EN
    ,
    output logic signed [15:0] bias_q
`endif
);

    localparam int ACC_W  = 30 + LOG2_WIN;
    localparam int BIAS_W = 16 + LOG2_WIN;

    logic signed [15:0] w_ideal;
    logic signed [15:0] w_err;
    logic [14:0]        w_mag;
    logic [29:0]        w_sq;

    logic signed [15:0] r_err;
    logic               r_v1;
    logic [29:0]        r_sq;
    logic               r_v2;
    logic [ACC_W-1:0]   r_acc;

    assign w_ideal = in_sample[15] ? -Q13_ONE : Q13_ONE;
    assign w_err   = in_sample - w_ideal;

    // |err| <= 24576 fits in 15 bits, so the square fits exactly in 30 bits
    assign w_mag = r_err[15] ? 15'(-r_err) : 15'(r_err);
    assign w_sq  = 30'(w_mag) * 30'(w_mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
            r_v1  <= 1'b0;
            r_sq  <= '0;
            r_v2  <= 1'b0;
            r_acc <= '0;
        end else if (clear) begin
            r_err <= '0;
            r_v1  <= 1'b0;
            r_sq  <= '0;
            r_v2  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_v1 <= acc_en;
            if (acc_en) begin
                r_err <= w_err;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sq <= w_sq;
            end
            if (r_v2) begin
                r_acc <= r_acc + {{LOG2_WIN{1'b0}}, r_sq};
            end
        end
    end

    assign pwr_q = r_acc[LOG2_WIN+Q13_FRAC +: 17];

`ifdef NOISE_EST_BIAS_EN
    logic signed [BIAS_W-1:0] r_bias_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bias_acc <= '0;
        end else if (clear) begin
            r_bias_acc <= '0;
        end else if (r_v1) begin
            r_bias_acc <= r_bias_acc + {{LOG2_WIN{r_err[15]}}, r_err};
        end
    end

    // Bit selection of the sign-extended sum is an arithmetic shift (floor)
    assign bias_q = r_bias_acc[LOG2_WIN +: 16];
`endif

endmodule
`default_nettype wire

// File: rtl/channel_noise_estimator.sv
`default_nettype none
// ============================================================================
// Module      : channel_noise_estimator
// Description : Windowed BPSK noise-power meter (Q2.13). Optional mean-error
//               output is enabled by defining NOISE_EST_BIAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_noise_estimator
    import noise_est_pkg::*;
#(
    parameter int LOG2_WIN = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [15:0] in_sample,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [15:0]        pwr,
    output logic               pwr_valid,
    input  logic               pwr_ready
`ifdef NOISE_EST_BIAS_EN
    ,
    output logic signed [15:0] bias
`endif
);

    localparam logic [LOG2_WIN:0] c_win_last = {1'b0, {LOG2_WIN{1'b1}}};

    state_t            r_state;
    state_t            w_state_next;
    logic [LOG2_WIN:0] r_count;
    logic [1:0]        r_flush;
    logic [15:0]       r_pwr;
    logic              w_accept;
    logic              w_load;
    logic              w_clear;
    logic [16:0]       w_pwr_q;

`ifdef NOISE_EST_BIAS_EN
    logic signed [15:0] w_bias_q;
    logic signed [15:0] r_bias;
`endif

    assign w_accept = in_valid && (r_state == RUN);

    noise_est_datapath #(
        .LOG2_WIN (LOG2_WIN)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .acc_en    (w_accept),
        .in_sample (in_sample),
        .pwr_q     (w_pwr_q)
`ifdef NOISE_EST_BIAS_EN
        ,
        .bias_q    (w_bias_q)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_accept && (r_count == c_win_last)) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                // two drain cycles, then acc holds the final sum
                if (r_flush == 2'd2) begin
                    w_load       = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (pwr_ready) begin
                    w_clear      = 1'b1;
                    w_state_next = en ? RUN : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_flush <= '0;
            r_pwr   <= '0;
        end else begin
            if (w_clear) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + 1'b1;
            end

            if ((r_state == FLUSH) && !w_load) begin
                r_flush <= r_flush + 2'd1;
            end else begin
                r_flush <= '0;
            end

            if (w_load) begin
                r_pwr <= w_pwr_q[16] ? PWR_MAX : w_pwr_q[15:0];
            end
        end
    end

`ifdef NOISE_EST_BIAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bias <= '0;
        end else if (w_load) begin
            r_bias <= w_bias_q;
        end
    end

    assign bias = r_bias;
`endif

    assign in_ready  = (r_state == RUN);
    assign pwr_valid = (r_state == HOLD);
    assign pwr       = r_pwr;

endmodule
`default_nettype wire
